fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and index helper for the command-FIFO write arbiter
// and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 18;
    localparam int unsigned DEF_TIMEOUT    = 64;

    // Modulo increment that also works for non-power-of-two requester counts.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request searching from
// owner+1 upwards, wrapping modulo NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] owner,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 valid
);

    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        idx   = owner;
        valid = 1'b0;
        cand  = owner;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_WIDTH'(next_idx(32'(cand), NUM_REQ));
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-granular round-robin arbiter sharing the command FIFO write port,
// with forced release of an owner that stops requesting.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned TO_WIDTH   = $clog2(TIMEOUT + 1),
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    input  logic [NUM_REQ-1:0]            i_Req,
    input  logic [NUM_REQ-1:0]            i_Req_Last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
    output logic [NUM_REQ-1:0]            o_Ack,
    output logic                          o_Timeout,
    input  logic                          i_Fifo_Full,
    output logic                          o_Fifo_Data_Valid,
    output logic [DATA_WIDTH-1:0]         o_Fifo_Data,
    output logic                          o_Diag_State,
    output logic [IDX_WIDTH-1:0]          o_Diag_Owner
);

    arb_state_e            state_q, state_d;
    logic [IDX_WIDTH-1:0]  owner_q, owner_d;
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  timeout_q, timeout_d;

    logic                  can_write;
    logic [IDX_WIDTH-1:0]  win_idx;
    logic                  win_valid;
    logic [DATA_WIDTH-1:0] win_data;
    logic [DATA_WIDTH-1:0] owner_data;

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req   (i_Req),
        .owner (owner_q),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        win_data   = '0;
        owner_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_WIDTH'(k) == win_idx) win_data = i_Req_Data[k*DATA_WIDTH +: DATA_WIDTH];
            if (IDX_WIDTH'(k) == owner_q) owner_data = i_Req_Data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A pending write blocks acceptance, so the full flag is fresh at the next decision.
    assign can_write = ~i_Fifo_Full & ~valid_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        data_d    = '0;
        ack_d     = '0;
        timeout_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (can_write && win_valid) begin
                    owner_d        = win_idx;
                    valid_d        = 1'b1;
                    data_d         = win_data;
                    ack_d[win_idx] = 1'b1;
                    if (!i_Req_Last[win_idx]) begin
                        state_d = ARB_LOCKED;
                        cnt_d   = '0;
                    end
                end
            end
            ARB_LOCKED: begin
                if (i_Req[owner_q]) begin
                    if (can_write) begin
                        valid_d        = 1'b1;
                        data_d         = owner_data;
                        ack_d[owner_q] = 1'b1;
                        cnt_d          = '0;
                        if (i_Req_Last[owner_q]) state_d = ARB_IDLE;
                    end
                end else if (cnt_q >= TO_WIDTH'(TIMEOUT - 1)) begin
                    // This idle cycle brings the count to TIMEOUT: release now.
                    state_d   = ARB_IDLE;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= IDX_WIDTH'(NUM_REQ - 1);
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_Ack             = ack_q;
    assign o_Timeout         = timeout_q;
    assign o_Fifo_Data_Valid = valid_q;
    assign o_Fifo_Data       = data_q;
    assign o_Diag_State      = state_q;
    assign o_Diag_Owner      = owner_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, rotation, packet lock,
// FIFO-full back-pressure, owner timeout and mid-packet reset.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 18;

    logic           i_Clk = 1'b0;
    logic           i_Rst_n;
    logic [NR-1:0]  i_Req;
    logic [NR-1:0]  i_Req_Last;
    logic [NR*DW-1:0] i_Req_Data;
    logic [NR-1:0]  o_Ack;
    logic           o_Timeout;
    logic           i_Fifo_Full;
    logic           o_Fifo_Data_Valid;
    logic [DW-1:0]  o_Fifo_Data;
    logic           o_Diag_State;
    logic [1:0]     o_Diag_Owner;

    int tests = 0;
    int fails = 0;

    fifo_write_arbiter dut (
        .i_Clk             (i_Clk),
        .i_Rst_n           (i_Rst_n),
        .i_Req             (i_Req),
        .i_Req_Last        (i_Req_Last),
        .i_Req_Data        (i_Req_Data),
        .o_Ack             (o_Ack),
        .o_Timeout         (o_Timeout),
        .i_Fifo_Full       (i_Fifo_Full),
        .o_Fifo_Data_Valid (o_Fifo_Data_Valid),
        .o_Fifo_Data       (o_Fifo_Data),
        .o_Diag_State      (o_Diag_State),
        .o_Diag_Owner      (o_Diag_Owner)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [DW-1:0] v);
        i_Req_Data[k*DW +: DW] = v;
    endtask

    initial begin
        int exp_idx;

        i_Rst_n     = 1'b0;
        i_Req       = '0;
        i_Req_Last  = '0;
        i_Req_Data  = '0;
        i_Fifo_Full = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(o_Fifo_Data_Valid), 32'd0);
        check("rst_ack", 32'(o_Ack), 32'd0);
        check("rst_timeout", 32'(o_Timeout), 32'd0);
        check("rst_data", 32'(o_Fifo_Data), 32'd0);
        check("rst_state", 32'(o_Diag_State), 32'd0);
        check("rst_owner", 32'(o_Diag_Owner), 32'd3);
        i_Rst_n = 1'b1;

        // Single word from requester 0
        i_Req = 4'b0001; i_Req_Last = 4'b0001; set_data(0, 18'h00011);
        tick();
        check("t1_valid", 32'(o_Fifo_Data_Valid), 32'd1);
        check("t1_data", 32'(o_Fifo_Data), 32'h00011);
        check("t1_ack", 32'(o_Ack), 32'b0001);
        check("t1_owner", 32'(o_Diag_Owner), 32'd0);
        set_data(0, 18'h00022);
        tick();
        check("t1_gap_valid", 32'(o_Fifo_Data_Valid), 32'd0);
        check("t1_gap_ack", 32'(o_Ack), 32'd0);
        tick();
        check("t1_second", 32'(o_Fifo_Data), 32'h00022);
        check("t1_second_ack", 32'(o_Ack), 32'b0001);

        // Round-robin with all requesting single-word packets
        i_Req = 4'b1111; i_Req_Last = 4'b1111;
        for (int k = 0; k < NR; k++) set_data(k, 18'(32'h100 + k));
        for (int i = 0; i < 6; i++) begin
            exp_idx = (1 + i) % NR;
            tick();
            check("rr_gap", 32'(o_Fifo_Data_Valid), 32'd0);
            tick();
            check("rr_ack", 32'(o_Ack), 32'(4'b0001 << exp_idx));
            check("rr_data", 32'(o_Fifo_Data), 32'h100 + 32'(exp_idx));
            check("rr_state", 32'(o_Diag_State), 32'd0);
        end

        // Three-word packet from requester 1 while others request
        i_Req = 4'b0010; i_Req_Last = 4'b0000; set_data(1, 18'h00201);
        tick();
        tick();
        check("pk_w1_ack", 32'(o_Ack), 32'b0010);
        check("pk_w1_data", 32'(o_Fifo_Data), 32'h00201);
        check("pk_w1_state", 32'(o_Diag_State), 32'd1);
        i_Req = 4'b1111; i_Req_Last = 4'b1101; set_data(1, 18'h00202);
        tick();
        check("pk_gap_state", 32'(o_Diag_State), 32'd1);
        tick();
        check("pk_w2_ack", 32'(o_Ack), 32'b0010);
        check("pk_w2_data", 32'(o_Fifo_Data), 32'h00202);
        i_Req_Last = 4'b1111; set_data(1, 18'h00203);
        tick();
        tick();
        check("pk_w3_ack", 32'(o_Ack), 32'b0010);
        check("pk_w3_data", 32'(o_Fifo_Data), 32'h00203);
        check("pk_w3_state", 32'(o_Diag_State), 32'd0);
        i_Req = 4'b1101;
        tick();
        tick();
        check("pk_next_ack", 32'(o_Ack), 32'b0100);
        check("pk_next_data", 32'(o_Fifo_Data), 32'h00102);

        // FIFO full back-pressure
        i_Req = 4'b1111; i_Fifo_Full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("full_valid", 32'(o_Fifo_Data_Valid), 32'd0);
            check("full_ack", 32'(o_Ack), 32'd0);
        end
        i_Fifo_Full = 1'b0;
        tick();
        check("full_rel_ack", 32'(o_Ack), 32'b1000);
        check("full_rel_data", 32'(o_Fifo_Data), 32'h00103);
        tick();
        tick();
        check("full_next_ack", 32'(o_Ack), 32'b0001);
        check("full_next_data", 32'(o_Fifo_Data), 32'h00100);

        // Owner timeout: requester 2 opens a packet then goes quiet
        i_Req = 4'b0100; i_Req_Last = 4'b0000; set_data(2, 18'h00301);
        tick();
        tick();
        check("to_w1_ack", 32'(o_Ack), 32'b0100);
        check("to_w1_state", 32'(o_Diag_State), 32'd1);
        i_Req = 4'b1000; i_Req_Last = 4'b1000;
        for (int i = 0; i < 63; i++) tick();
        check("to_early", 32'(o_Timeout), 32'd0);
        check("to_early_state", 32'(o_Diag_State), 32'd1);
        check("to_blocked", 32'(o_Fifo_Data_Valid), 32'd0);
        tick();
        check("to_pulse", 32'(o_Timeout), 32'd1);
        check("to_state", 32'(o_Diag_State), 32'd0);
        check("to_owner", 32'(o_Diag_Owner), 32'd2);
        check("to_no_write", 32'(o_Fifo_Data_Valid), 32'd0);
        tick();
        check("to_pulse_end", 32'(o_Timeout), 32'd0);
        check("to_grant3", 32'(o_Ack), 32'b1000);

        // Reset in the middle of a packet
        i_Req = 4'b0010; i_Req_Last = 4'b0000; set_data(1, 18'h00401);
        tick();
        tick();
        check("mr_valid", 32'(o_Fifo_Data_Valid), 32'd1);
        check("mr_state", 32'(o_Diag_State), 32'd1);
        i_Rst_n = 1'b0;
        #1;
        check("mr_rst_valid", 32'(o_Fifo_Data_Valid), 32'd0);
        check("mr_rst_ack", 32'(o_Ack), 32'd0);
        check("mr_rst_state", 32'(o_Diag_State), 32'd0);
        check("mr_rst_owner", 32'(o_Diag_Owner), 32'd3);
        i_Req = 4'b1111; i_Req_Last = 4'b1111;
        tick();
        check("mr_hold", 32'(o_Fifo_Data_Valid), 32'd0);
        i_Rst_n = 1'b1;
        tick();
        check("mr_first_ack", 32'(o_Ack), 32'b0001);
        check("mr_first_owner", 32'(o_Diag_Owner), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
